// File: rtl/wrapper.sv
// Fractional-order (alpha = 0.5) Grunwald-Letnikov integrator of an internal step signal.
// An 8-tap MAC runs once per sample tick and the 16-bit result is shifted out on JA, MSB nibble first.
module wrapper #(
  parameter int unsigned SAMPLE_DIV = 64,
  parameter int unsigned STEP_VAL   = 256
) (
  input  logic       clk,
  input  logic       rst,
  output logic       led,
  output logic       OutInd,
  output logic       SigInd,
  output logic [3:0] JA
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned COEF_W = 16;
  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam int unsigned ACC_W  = 35;
  localparam int unsigned FRAC_W = 14;
  localparam int unsigned TAPS   = 8;
  localparam int unsigned TAP_W  = 3;
  localparam int unsigned K_W    = 4;
  localparam int unsigned NIB_W  = 2;
  localparam int unsigned DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2,
    SEND = 2'd3
  } state_e;

  // Q2.14 binomial weights: c0 = 1, c_j = c_{j-1} * (j - 0.5) / j
  function automatic logic [COEF_W-1:0] coef(input logic [TAP_W-1:0] idx);
    case (idx)
      3'd0:    coef = COEF_W'(16384);
      3'd1:    coef = COEF_W'(8192);
      3'd2:    coef = COEF_W'(6144);
      3'd3:    coef = COEF_W'(5120);
      3'd4:    coef = COEF_W'(4480);
      3'd5:    coef = COEF_W'(4032);
      3'd6:    coef = COEF_W'(3696);
      default: coef = COEF_W'(3432);
    endcase
  endfunction

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                tick_c;
  logic [DATA_W-1:0]   hist_q [TAPS];
  logic [K_W-1:0]      k_q, k_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [TAP_W-1:0]    j_q, j_d;
  logic [DATA_W-1:0]   y_q, y_d;
  logic [NIB_W-1:0]    nib_q, nib_d;
  logic                sig_q, sig_d;
  logic                out_q, out_d;
  logic                led_q, led_d;
  logic [3:0]          ja_q, ja_d;
  logic [PROD_W-1:0]   prod_c;
  logic [ACC_W-1:0]    acc_sh_c;
  logic [DATA_W-1:0]   y_sat_c;

  // Free-running sample divider; the first tick lands SAMPLE_DIV clocks after reset release
  assign tick_c = (div_q == DIV_W'(SAMPLE_DIV - 1));
  assign div_d  = tick_c ? '0 : div_q + DIV_W'(1);
  assign sig_d  = tick_c ? ~sig_q : sig_q;
  assign k_d    = (tick_c && (k_q != K_W'(TAPS))) ? k_q + K_W'(1) : k_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q <= '0;
      sig_q <= 1'b0;
      k_q   <= '0;
    end else begin
      div_q <= div_d;
      sig_q <= sig_d;
      k_q   <= k_d;
    end
  end

  // Sample history shifts on every tick, independent of the FSM state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(TAPS); i++) hist_q[i] <= '0;
    end else if (tick_c) begin
      hist_q[0] <= DATA_W'(STEP_VAL);
      for (int i = 1; i < int'(TAPS); i++) hist_q[i] <= hist_q[i-1];
    end
  end

  assign prod_c   = PROD_W'(coef(j_q)) * PROD_W'(hist_q[j_q]);
  assign acc_sh_c = acc_q >> FRAC_W;
  assign y_sat_c  = (|acc_sh_c[ACC_W-1:DATA_W]) ? '1 : acc_sh_c[DATA_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tick_c) state_d = MAC;
      MAC:     if (j_q == TAP_W'(TAPS - 1)) state_d = DONE;
      DONE:    state_d = SEND;
      SEND:    if (nib_q == NIB_W'(3)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values; a tick outside IDLE only shifts history
  always_comb begin
    acc_d = acc_q;
    j_d   = j_q;
    y_d   = y_q;
    nib_d = nib_q;
    out_d = 1'b0;
    led_d = led_q;
    ja_d  = 4'h0;
    case (state_q)
      IDLE: begin
        if (tick_c) begin
          acc_d = '0;
          j_d   = '0;
        end
      end
      MAC: begin
        acc_d = acc_q + ACC_W'(prod_c);
        j_d   = j_q + TAP_W'(1);
      end
      DONE: begin
        y_d   = y_sat_c;
        out_d = 1'b1;
        led_d = led_q | (k_q == K_W'(TAPS));
        nib_d = '0;
      end
      SEND: begin
        case (nib_q)
          2'd0:    ja_d = y_q[15:12];
          2'd1:    ja_d = y_q[11:8];
          2'd2:    ja_d = y_q[7:4];
          default: ja_d = y_q[3:0];
        endcase
        nib_d = nib_q + NIB_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
      j_q   <= '0;
      y_q   <= '0;
      nib_q <= '0;
      out_q <= 1'b0;
      led_q <= 1'b0;
      ja_q  <= 4'h0;
    end else begin
      acc_q <= acc_d;
      j_q   <= j_d;
      y_q   <= y_d;
      nib_q <= nib_d;
      out_q <= out_d;
      led_q <= led_d;
      ja_q  <= ja_d;
    end
  end

  assign led    = led_q;
  assign OutInd = out_q;
  assign SigInd = sig_q;
  assign JA     = ja_q;

endmodule

// File: tb/tb_wrapper.sv
// Directed bench for wrapper: default step, saturating step, and fastest sample rate, all sharing clk/rst.
module tb_wrapper;

  logic clk = 1'b0;
  logic rst;

  logic       led_a, oi_a, sig_a;
  logic [3:0] ja_a;
  logic       led_b, oi_b, sig_b;
  logic [3:0] ja_b;
  logic       led_c, oi_c, sig_c;
  logic [3:0] ja_c;

  wrapper #(.SAMPLE_DIV(64), .STEP_VAL(256)) dut_a (
    .clk(clk), .rst(rst), .led(led_a), .OutInd(oi_a), .SigInd(sig_a), .JA(ja_a));
  wrapper #(.SAMPLE_DIV(64), .STEP_VAL(65535)) dut_b (
    .clk(clk), .rst(rst), .led(led_b), .OutInd(oi_b), .SigInd(sig_b), .JA(ja_b));
  wrapper #(.SAMPLE_DIV(16), .STEP_VAL(256)) dut_c (
    .clk(clk), .rst(rst), .led(led_c), .OutInd(oi_c), .SigInd(sig_c), .JA(ja_c));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int exp_y [10] = '{256, 384, 480, 560, 630, 693, 750, 804, 804, 804};

  // Capture results per instance (0 = a, 1 = b, 2 = c)
  int          ncap [3];
  logic [15:0] ycap [3][16];
  int          ocnt [3];
  int          ocyc [3][16];
  int          scnt;
  int          scyc [16];
  int          led_rise;
  int          wide;
  int          stray;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Cycle 1 is the first rising edge after the call; outputs sampled on the falling edge
  task automatic run_capture(input int ncyc);
    int          pend [3];
    logic [15:0] yacc [3];
    logic [3:0]  jv [3];
    logic        ov [3];
    logic        prev_sig, prev_oi;
    for (int d = 0; d < 3; d++) begin
      ncap[d] = 0; ocnt[d] = 0; pend[d] = 0; yacc[d] = '0;
      for (int i = 0; i < 16; i++) begin ycap[d][i] = '0; ocyc[d][i] = 0; end
    end
    for (int i = 0; i < 16; i++) scyc[i] = 0;
    scnt = 0; led_rise = -1; wide = 0; stray = 0;
    prev_sig = sig_a; prev_oi = oi_a;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      jv[0] = ja_a; jv[1] = ja_b; jv[2] = ja_c;
      ov[0] = oi_a; ov[1] = oi_b; ov[2] = oi_c;
      for (int d = 0; d < 3; d++) begin
        if (pend[d] == 0) begin
          if (jv[d] !== 4'h0) stray++;
        end else begin
          yacc[d] = {yacc[d][11:0], jv[d]};
          pend[d]--;
          if (pend[d] == 0 && ncap[d] < 16) begin
            ycap[d][ncap[d]] = yacc[d];
            ncap[d]++;
          end
        end
        if (ov[d]) begin
          pend[d] = 4;
          yacc[d] = '0;
          if (ocnt[d] < 16) begin ocyc[d][ocnt[d]] = cyc; ocnt[d]++; end
        end
      end
      if (sig_a !== prev_sig && scnt < 16) begin scyc[scnt] = cyc; scnt++; end
      prev_sig = sig_a;
      if (oi_a && prev_oi) wide++;
      prev_oi = oi_a;
      if (led_a === 1'b1 && led_rise < 0) led_rise = cyc;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    #11;
    n_checks++;
    if ({led_a, oi_a, sig_a, ja_a} !== 7'd0) begin
      n_fail++; $display("FAIL reset_a: got %b expected 0000000", {led_a, oi_a, sig_a, ja_a});
    end
    n_checks++;
    if ({led_b, oi_b, sig_b, ja_b} !== 7'd0) begin
      n_fail++; $display("FAIL reset_b: got %b expected 0000000", {led_b, oi_b, sig_b, ja_b});
    end
    n_checks++;
    if ({led_c, oi_c, sig_c, ja_c} !== 7'd0) begin
      n_fail++; $display("FAIL reset_c: got %b expected 0000000", {led_c, oi_c, sig_c, ja_c});
    end
  endtask

  task automatic test_first_result();
    do_reset();
    run_capture(80);
    n_checks++;
    if (ocyc[0][0] !== 73) begin
      n_fail++; $display("FAIL first_outind_cycle: got %0d expected 73", ocyc[0][0]);
    end
    n_checks++;
    if (ycap[0][0] !== 16'd256) begin
      n_fail++; $display("FAIL first_y: got %0d expected 256", ycap[0][0]);
    end
    n_checks++;
    if (scyc[0] !== 64) begin
      n_fail++; $display("FAIL first_sigind_toggle: got %0d expected 64", scyc[0]);
    end
    n_checks++;
    if (stray !== 0) begin
      n_fail++; $display("FAIL ja_idle_zero: got %0d nonzero cycles expected 0", stray);
    end
    n_checks++;
    if (led_rise !== -1) begin
      n_fail++; $display("FAIL led_early: got rise at %0d expected none", led_rise);
    end
  endtask

  task automatic test_sequence();
    do_reset();
    run_capture(660);
    n_checks++;
    if (ncap[0] !== 10) begin
      n_fail++; $display("FAIL seq_count: got %0d expected 10", ncap[0]);
    end
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (ycap[0][i] !== 16'(exp_y[i])) begin
        n_fail++; $display("FAIL seq_y[%0d]: got %0d expected %0d", i, ycap[0][i], exp_y[i]);
      end
      n_checks++;
      if (ocyc[0][i] !== 64 * (i + 1) + 9) begin
        n_fail++; $display("FAIL seq_outind_cycle[%0d]: got %0d expected %0d", i, ocyc[0][i], 64 * (i + 1) + 9);
      end
      n_checks++;
      if (scyc[i] !== 64 * (i + 1)) begin
        n_fail++; $display("FAIL seq_sigind_cycle[%0d]: got %0d expected %0d", i, scyc[i], 64 * (i + 1));
      end
    end
    n_checks++;
    if (scnt !== 10) begin
      n_fail++; $display("FAIL seq_sigind_count: got %0d expected 10", scnt);
    end
    n_checks++;
    if (wide !== 0) begin
      n_fail++; $display("FAIL seq_outind_width: got %0d wide cycles expected 0", wide);
    end
    n_checks++;
    if (led_rise !== 521) begin
      n_fail++; $display("FAIL seq_led_rise: got %0d expected 521", led_rise);
    end
    n_checks++;
    if (stray !== 0) begin
      n_fail++; $display("FAIL seq_ja_idle_zero: got %0d nonzero cycles expected 0", stray);
    end
  endtask

  task automatic test_reset_mid_mac();
    do_reset();
    run_capture(195);
    n_checks++;
    if (sig_a !== 1'b1) begin
      n_fail++; $display("FAIL mid_mac_sig_before: got %b expected 1", sig_a);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({led_a, oi_a, sig_a, ja_a} !== 7'd0) begin
      n_fail++; $display("FAIL mid_mac_async_clear: got %b expected 0000000", {led_a, oi_a, sig_a, ja_a});
    end
    @(negedge clk);
    rst = 1'b1;
    run_capture(80);
    n_checks++;
    if (ocnt[0] !== 1 || ocyc[0][0] !== 73) begin
      n_fail++; $display("FAIL mid_mac_restart_cycle: got %0d pulses first at %0d expected 1 at 73", ocnt[0], ocyc[0][0]);
    end
    n_checks++;
    if (ycap[0][0] !== 16'd256) begin
      n_fail++; $display("FAIL mid_mac_restart_y: got %0d expected 256", ycap[0][0]);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    run_capture(300);
    n_checks++;
    if (ncap[1] !== 4) begin
      n_fail++; $display("FAIL sat_count: got %0d expected 4", ncap[1]);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (ycap[1][i] !== 16'hFFFF) begin
        n_fail++; $display("FAIL sat_y[%0d]: got %0h expected ffff", i, ycap[1][i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    run_capture(200);
    n_checks++;
    if (ocnt[2] !== 11 || ncap[2] !== 11) begin
      n_fail++; $display("FAIL b2b_count: got %0d pulses %0d results expected 11", ocnt[2], ncap[2]);
    end
    for (int i = 0; i < 11; i++) begin
      n_checks++;
      if (ycap[2][i] !== 16'((i < 10) ? exp_y[i] : 804)) begin
        n_fail++; $display("FAIL b2b_y[%0d]: got %0d expected %0d", i, ycap[2][i], (i < 10) ? exp_y[i] : 804);
      end
      n_checks++;
      if (ocyc[2][i] !== 16 * (i + 1) + 9) begin
        n_fail++; $display("FAIL b2b_outind_cycle[%0d]: got %0d expected %0d", i, ocyc[2][i], 16 * (i + 1) + 9);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_result();
    test_sequence();
    test_reset_mid_mac();
    test_saturation();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wrapper.md
WRAPPER -- requirements
Module: wrapper

Interface
REQ-001 SHALL have parameter SAMPLE_DIV, default 64: clocks per input sample (minimum 16).
REQ-002 SHALL have parameter STEP_VAL, default 256: internal input sample value, unsigned Q8.8 (256 = 1.0).
REQ-003 SHALL have port clk  input  1  sole system clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous and active-low.
REQ-005 SHALL have port led  output  1  window-full indicator.
REQ-006 SHALL have port OutInd  output  1  one-cycle pulse: new result valid.
REQ-007 SHALL have port SigInd  output  1  toggles on every new input sample.
REQ-008 SHALL have port JA  output  4  serialized result nibble.

Function
REQ-009 SHALL compute a fractional-order (alpha = 0.5) Riemann-Liouville/Grunwald-Letnikov integral of an internally generated step signal over an 8-tap window.
REQ-010 SHALL generate a sample tick from a free-running counter every SAMPLE_DIV clocks; the first tick occurs SAMPLE_DIV clocks after reset release.
REQ-011 On each tick SHALL shift an 8-entry 16-bit history (h[7] dropped, h[0] = STEP_VAL) and toggle SigInd.
REQ-012 SHALL hold coefficient ROM w[0..7] unsigned Q2.14 = 16384, 8192, 6144, 5120, 4480, 4032, 3696, 3432 (c0 = 1, c_j = c_{j-1}*(j-0.5)/j).
REQ-013 History entries not yet written since reset SHALL be zero.
REQ-014 FSM states: IDLE, MAC, DONE, SEND; reset state IDLE.
REQ-015 IDLE -> MAC on tick; accumulator cleared, tap index j = 0.
REQ-016 MAC: one term per clock, acc += w[j]*h[j] (16x16 unsigned, 35-bit accumulator), j = 0..7; after j = 7 -> DONE (8 cycles).
REQ-017 DONE (1 cycle): y = acc >> 14 (truncate), saturate to 16'hFFFF if larger; register y; OutInd = 1 for this cycle only; -> SEND.
REQ-018 SEND: JA presents y[15:12], y[11:8], y[7:4], y[3:0] on 4 consecutive clocks, MSB nibble first; then -> IDLE.
REQ-019 Outside SEND, JA SHALL be 4'h0.
REQ-020 Latency: tick to OutInd = 9 clocks; tick to last nibble = 13 clocks.
REQ-021 A tick arriving while not in IDLE cannot occur (SAMPLE_DIV >= 16); the FSM SHALL nevertheless ignore such a tick for computation while still performing the history shift.
REQ-022 led SHALL go high at the DONE of the 8th sample after reset and remain high until reset.
REQ-023 Sample counter (k) SHALL saturate at 8; no wrap.

Reset
REQ-024 rst = 0 SHALL asynchronously clear: history, accumulator, y, counters, SigInd = 0, OutInd = 0, led = 0, JA = 0, FSM = IDLE.
REQ-025 Reset asserted mid-MAC or mid-SEND SHALL abort immediately; after release operation restarts as from power-up (first result again 256).
REQ-026 Outputs SHALL be registered; no combinational path from rst deassertion to outputs except the async clear.

Verification
REQ-027 Release rst, default parameters -> first OutInd 73 clocks after release (64 + 9), y = 256, JA sequence 0,1,0,0.
REQ-028 Run 10 samples -> y sequence 256, 384, 480, 560, 630, 693, 750, 804, 804, 804.
REQ-029 Same run -> SigInd toggles every 64 clocks; OutInd exactly one cycle wide per sample; led rises at the 8th OutInd (y = 804, JA 0,3,2,4).
REQ-030 Assert rst during MAC of sample 3 -> all outputs 0 immediately; after release next result 256.
REQ-031 STEP_VAL = 65535 -> y saturates correctly per truncation: sample 0 y = 65535, later samples 16'hFFFF (saturated).
REQ-032 SAMPLE_DIV = 16 -> back-to-back samples, no tick lost, results identical to REQ-028.
